// File: rtl/clk_div_prog_if.sv
// Configuration channel of clk_div_prog: a divisor/high-phase pair offered with a
// valid/ready handshake.
// A configuration transfers on a rising clk edge where cfg_valid and cfg_ready are both 1.
// The master holds cfg_div/cfg_high stable while cfg_valid is high. cfg_ready depends only
// on the slave's registered state, never on cfg_valid.
interface clk_div_prog_if #(
    parameter int W = 16
) ();
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;

    modport master (output cfg_valid, output cfg_div, output cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, input cfg_high, output cfg_ready);
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider with a registered output clock and a start-of-period tick.
// A new divisor/high pair can be loaded at run time; it takes effect at a period boundary.
module clk_div_prog #(
    parameter int W        = 16,
    parameter int DEF_DIV  = 100,
    parameter int DEF_HIGH = 50
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    clk_div_prog_if.slave  cfg,
    output logic           o_clk,
    output logic           o_tick,
    output logic           cfg_err,
    output logic           o_dbg_state,
    output logic [W-1:0]   o_dbg_cnt
);

    if (DEF_DIV < 2 || DEF_HIGH < 1 || DEF_HIGH > DEF_DIV - 1 ||
        longint'(DEF_DIV) > ((longint'(1) << W) - 1)) begin : g_bad_params
        $error("clk_div_prog: illegal DEF_DIV/DEF_HIGH for width W");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_cnt,       w_cnt_nxt;
    logic [W-1:0] r_div,       w_div_nxt;
    logic [W-1:0] r_high,      w_high_nxt;
    logic [W-1:0] r_pend_div,  w_pend_div_nxt;
    logic [W-1:0] r_pend_high, w_pend_high_nxt;
    logic         r_pend_vld,  w_pend_vld_nxt;
    logic         r_clk,       w_clk_nxt;
    logic         r_tick,      w_tick_nxt;
    logic         r_err,       w_err_nxt;

    logic         w_accept;
    logic         w_legal;
    logic [W-1:0] w_run_nxt;
    logic         w_wrap;
    logic         w_load_pend;
    logic [W-1:0] w_eff_div;
    logic [W-1:0] w_eff_high;
    logic         w_clk_run;

    assign cfg.cfg_ready = !r_pend_vld;
    assign w_accept      = cfg.cfg_valid && !r_pend_vld;
    // high <= div-1 is the same as high < div once div >= 2
    assign w_legal       = (cfg.cfg_div >= W'(2)) && (cfg.cfg_high != '0) &&
                           (cfg.cfg_high < cfg.cfg_div);

    // Wrap is decided by the old divisor so the running period always completes.
    assign w_run_nxt   = (r_cnt == r_div - W'(1)) ? '0 : r_cnt + W'(1);
    assign w_wrap      = (w_run_nxt == '0);
    assign w_load_pend = w_wrap && r_pend_vld;
    assign w_eff_div   = w_load_pend ? r_pend_div  : r_div;
    assign w_eff_high  = w_load_pend ? r_pend_high : r_high;
    assign w_clk_run   = (w_run_nxt >= (w_eff_div - w_eff_high));

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_div_nxt       = r_div;
        w_high_nxt      = r_high;
        w_pend_div_nxt  = r_pend_div;
        w_pend_high_nxt = r_pend_high;
        w_pend_vld_nxt  = r_pend_vld;
        w_clk_nxt       = r_clk;
        w_tick_nxt      = r_tick;
        w_err_nxt       = r_err;

        if (w_accept) begin
            w_err_nxt = !w_legal;
        end

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_clk_nxt  = 1'b0;
                w_tick_nxt = 1'b0;
                if (w_accept && w_legal) begin
                    w_div_nxt  = cfg.cfg_div;
                    w_high_nxt = cfg.cfg_high;
                end
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_tick_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_cnt_nxt  = w_run_nxt;
                    w_tick_nxt = w_wrap;
                    w_clk_nxt  = w_clk_run;
                    if (w_load_pend) begin
                        w_div_nxt      = r_pend_div;
                        w_high_nxt     = r_pend_high;
                        w_pend_vld_nxt = 1'b0;
                    end
                    // Acceptance needs an empty slot, so this never collides with the load above.
                    if (w_accept && w_legal) begin
                        w_pend_div_nxt  = cfg.cfg_div;
                        w_pend_high_nxt = cfg.cfg_high;
                        w_pend_vld_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_clk_nxt   = 1'b0;
                    w_tick_nxt  = 1'b0;
                    if (r_pend_vld) begin
                        w_div_nxt      = r_pend_div;
                        w_high_nxt     = r_pend_high;
                        w_pend_vld_nxt = 1'b0;
                    end else if (w_accept && w_legal) begin
                        // Stopping: nothing left to defer it to, so load directly.
                        w_div_nxt  = cfg.cfg_div;
                        w_high_nxt = cfg.cfg_high;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_div       <= W'(DEF_DIV);
            r_high      <= W'(DEF_HIGH);
            r_pend_div  <= '0;
            r_pend_high <= '0;
            r_pend_vld  <= 1'b0;
            r_clk       <= 1'b0;
            r_tick      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_div       <= w_div_nxt;
            r_high      <= w_high_nxt;
            r_pend_div  <= w_pend_div_nxt;
            r_pend_high <= w_pend_high_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_clk       <= w_clk_nxt;
            r_tick      <= w_tick_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign o_clk       = r_clk;
    assign o_tick      = r_tick;
    assign cfg_err     = r_err;
    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

endmodule
